// File: rtl/ifu_pkg.sv
// Shared IFU types and constants: cache-line geometry, cache<->fill-engine
// request/response structs and the fill-engine state encoding.
package ifu_pkg;

  localparam int CL_WIDTH   = 128;
  localparam int WORD_WIDTH = 32;
  localparam int FILL_BEATS = CL_WIDTH / WORD_WIDTH;

  typedef struct packed {
    logic [31:0] fill_requested_address;
    logic        fill_requested_address_valid;
  } t_cache2i_mem_req;

  typedef struct packed {
    logic                valid;
    logic [31:0]         address;
    logic [CL_WIDTH-1:0] filled_instruction;
  } t_i_mem2cache_rsp;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    RESP
  } t_fill_state;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } t_imem_word_req;

  // Cache lines are 16-byte aligned; the low nibble never reaches memory.
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return a & ~32'h0000_000F;
  endfunction

endpackage

// File: rtl/ifu_fill_fifo.sv
// Fill-request FIFO holding line addresses; all entries and their occupancy
// bits are exported so the top level can look for duplicate lines.
module ifu_fill_fifo import ifu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [31:0]            push_data_i,
  input  logic                   pop_i,
  output logic [31:0]            pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH-1:0]       entry_vld_o,
  output logic [DEPTH-1:0][31:0] entry_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0]          vld_q, vld_d;
  logic [DEPTH-1:0][31:0]    mem_q;
  logic                      pop_ok;

  assign pop_ok  = pop_i && !empty_o;
  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;

  // Pop clears before push sets, so a full FIFO can pop and push the same slot.
  always_comb begin
    vld_d = vld_q;
    if (pop_ok) vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o  = mem_q[rd_ptr_q];
  assign entry_vld_o = vld_q;
  assign entry_o     = mem_q;

endmodule

// File: rtl/ifu_imem_fill.sv
// Instruction-memory fill engine: queues line fills, reads each line as word
// beats and returns the assembled line. Optional IFU_FILL_DEDUP_EN drops
// requests for a line that is already queued or in flight.
module ifu_imem_fill import ifu_pkg::*; #(
  parameter int REQ_FIFO_DEPTH = 2
) (
  input  logic             Clk,
  input  logic             RstN,
  input  t_cache2i_mem_req cache2i_mem_req,
  output logic             fill_req_ready,
  output t_i_mem2cache_rsp i_mem2cache_rsp,
  output logic             mem_req_valid,
  output logic [31:0]      mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  output logic             fill_busy
);

  localparam int BEATS = FILL_BEATS;
  localparam int CW    = $clog2(BEATS);

`ifdef IFU_FILL_DEDUP_EN
  localparam bit DEDUP_EN = 1'b1;
`else
  localparam bit DEDUP_EN = 1'b0;
`endif

  t_fill_state                     state_q, state_d;
  logic [31:0]                     line_addr_q, line_addr_d;
  logic [CW-1:0]                   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]                   rsp_cnt_q, rsp_cnt_d;
  logic [CL_WIDTH-1:0]             line_q, line_d;
  t_i_mem2cache_rsp                rsp_q, rsp_d;
  t_imem_word_req                  word_req;

  logic                            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]                     fifo_head;
  logic [REQ_FIFO_DEPTH-1:0]       fifo_vld;
  logic [REQ_FIFO_DEPTH-1:0][31:0] fifo_entries;
  logic [31:0]                     req_line;
  logic                            accept, dup;

  assign req_line       = line_align(cache2i_mem_req.fill_requested_address);
  assign fill_req_ready = !fifo_full;
  assign accept         = cache2i_mem_req.fill_requested_address_valid && fill_req_ready;

  always_comb begin
    dup = (state_q != IDLE) && (line_addr_q == req_line);
    for (int i = 0; i < REQ_FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_entries[i] == req_line)) dup = 1'b1;
    end
  end

  // A duplicate is still acknowledged through ready; it just never enters the queue.
  assign fifo_push = accept && !(DEDUP_EN && dup);

  ifu_fill_fifo #(
    .DEPTH(REQ_FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_ni     (RstN),
    .push_i     (fifo_push),
    .push_data_i(req_line),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .entry_vld_o(fifo_vld),
    .entry_o    (fifo_entries)
  );

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    line_d      = line_q;
    fifo_pop    = 1'b0;
    word_req    = '0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          line_addr_d = fifo_head;
          issue_cnt_d = '0;
          rsp_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        word_req.valid = 1'b1;
        word_req.addr  = line_addr_q + 32'({issue_cnt_q, 2'b00});
        if (mem_req_ready) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
          if (issue_cnt_q == CW'(BEATS - 1)) state_d = COLLECT;
        end
      end
      COLLECT: ;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Responses may overtake the last issue; the final beat always wins to RESP.
    if (((state_q == ISSUE) || (state_q == COLLECT)) && mem_rsp_valid) begin
      for (int b = 0; b < BEATS; b++) begin
        if (rsp_cnt_q == CW'(b)) line_d[b*WORD_WIDTH +: WORD_WIDTH] = mem_rsp_data;
      end
      rsp_cnt_d = rsp_cnt_q + CW'(1);
      if (rsp_cnt_q == CW'(BEATS - 1)) state_d = RESP;
    end
  end

  always_comb begin
    rsp_d       = rsp_q;
    rsp_d.valid = 1'b0;
    if (state_d == RESP) begin
      rsp_d.valid              = 1'b1;
      rsp_d.address            = line_addr_q;
      rsp_d.filled_instruction = line_d;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      line_q      <= '0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      line_q      <= line_d;
      rsp_q       <= rsp_d;
    end
  end

  assign i_mem2cache_rsp = rsp_q;
  assign mem_req_valid   = word_req.valid;
  assign mem_req_addr    = word_req.addr;
  assign fill_busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ifu_imem_fill.sv
// Directed bench for ifu_imem_fill with a one-cycle-latency word memory model.
module tb_ifu_imem_fill;
  import ifu_pkg::*;

`ifdef IFU_FILL_DEDUP_EN
  localparam int DUP_RSPS = 1;
`else
  localparam int DUP_RSPS = 2;
`endif

  logic             Clk  = 1'b0;
  logic             RstN = 1'b1;
  t_cache2i_mem_req req;
  logic             fill_req_ready;
  t_i_mem2cache_rsp rsp;
  logic             mem_req_valid;
  logic [31:0]      mem_req_addr;
  logic             mem_req_ready = 1'b1;
  logic             mem_rsp_valid = 1'b0;
  logic [31:0]      mem_rsp_data  = 32'h0;
  logic             fill_busy;

  ifu_imem_fill #(.REQ_FIFO_DEPTH(2)) dut (
    .Clk            (Clk),
    .RstN           (RstN),
    .cache2i_mem_req(req),
    .fill_req_ready (fill_req_ready),
    .i_mem2cache_rsp(rsp),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .fill_busy      (fill_busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0]      iss_q[$];
  t_i_mem2cache_rsp rsp_q[$];
  int               rcyc_q[$];
  logic [31:0]      pend_q[$];
  logic             rsp_en = 1'b1;

  int a0, a1, a2, acc, nrsp;
  bit found, stable;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000123) return 32'h11 * ({30'b0, a[3:2]} + 32'd1);
    return a ^ 32'hCAFE_0000;
  endfunction

  // Memory: accept at the handshake edge, answer during the following cycle.
  always @(negedge Clk) begin
    if (!RstN) pend_q.delete();
    else if (mem_req_valid && mem_req_ready) pend_q.push_back(mem_word(mem_req_addr));
    @(posedge Clk);
    #1;
    if (RstN && rsp_en && pend_q.size() > 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pend_q.pop_front();
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
  end

  always @(negedge Clk) begin
    if (RstN) begin
      if (mem_req_valid && mem_req_ready) iss_q.push_back(mem_req_addr);
      if (rsp.valid) begin
        rsp_q.push_back(rsp);
        rcyc_q.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge Clk);
    #2;
  endtask

  task automatic clear_logs();
    iss_q.delete();
    rsp_q.delete();
    rcyc_q.delete();
  endtask

  task automatic push_req(input logic [31:0] a, output int acc_cyc);
    bit ok;
    ok      = 1'b0;
    acc_cyc = 0;
    req.fill_requested_address       = a;
    req.fill_requested_address_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (fill_req_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    chk("accept", 128'(ok), 128'(1));
    sync();
  endtask

  task automatic req_idle();
    req = '0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && rsp_q.size() < n; i++) sync();
    chk("rsp_count", 128'(rsp_q.size()), 128'(n));
  endtask

  task automatic chk_line(input string tag, input int idx, input logic [31:0] addr,
                          input logic [127:0] line);
    if (rsp_q.size() > idx) begin
      chk({tag, "_addr"}, 128'(rsp_q[idx].address), 128'(addr));
      chk({tag, "_line"}, rsp_q[idx].filled_instruction, line);
    end
  endtask

  task automatic chk_beats(input string tag, input int base, input logic [31:0] b0,
                           input logic [31:0] b1, input logic [31:0] b2, input logic [31:0] b3);
    logic [31:0] e[4];
    e = '{b0, b1, b2, b3};
    if (iss_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) chk(tag, 128'(iss_q[base+i]), 128'(e[i]));
    end else begin
      chk({tag, "_n"}, 128'(iss_q.size()), 128'(base + 4));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    #1 RstN = 1'b0;
    #2;
    chk("rst_rsp_vld",  128'(rsp.valid), 128'(0));
    chk("rst_rsp_addr", 128'(rsp.address), 128'(0));
    chk("rst_rsp_line", rsp.filled_instruction, 128'(0));
    chk("rst_mreq_vld", 128'(mem_req_valid), 128'(0));
    chk("rst_mreq_addr", 128'(mem_req_addr), 128'(0));
    chk("rst_busy",     128'(fill_busy), 128'(0));
    repeat (2) @(posedge Clk);
    #2 RstN = 1'b1;
    #1 chk("rst_ready", 128'(fill_req_ready), 128'(1));
    sync();

    // Single fill with latency check
    clear_logs();
    push_req(32'h0000_1234, acc);
    req_idle();
    wait_rsp(1, 40);
    chk_beats("t1_beat", 0, 32'h1230, 32'h1234, 32'h1238, 32'h123C);
    chk_line("t1", 0, 32'h0000_1230, 128'h00000044_00000033_00000022_00000011);
    if (rcyc_q.size() > 0) chk("t1_latency", 128'(rcyc_q[0] - acc), 128'(7));
    chk("t1_vld_drop", 128'(rsp.valid), 128'(0));
    chk("t1_hold_addr", 128'(rsp.address), 128'(32'h1230));
    chk("t1_hold_line", rsp.filled_instruction, 128'h00000044_00000033_00000022_00000011);
    chk("t1_idle", 128'(fill_busy), 128'(0));

    // Back-to-back requests fill the FIFO
    clear_logs();
    push_req(32'h100, a0);
    push_req(32'h200, a1);
    push_req(32'h300, a2);
    req_idle();
    chk("t2_consecutive", 128'(a2 - a0), 128'(2));
    @(negedge Clk);
    chk("t2_full_ready", 128'(fill_req_ready), 128'(0));
    chk("t2_busy", 128'(fill_busy), 128'(1));
    sync();
    wait_rsp(3, 80);
    chk_line("t2_r0", 0, 32'h100, 128'hCAFE010C_CAFE0108_CAFE0104_CAFE0100);
    chk_line("t2_r1", 1, 32'h200, 128'hCAFE020C_CAFE0208_CAFE0204_CAFE0200);
    chk_line("t2_r2", 2, 32'h300, 128'hCAFE030C_CAFE0308_CAFE0304_CAFE0300);
    chk("t2_beats", 128'(iss_q.size()), 128'(12));
    chk("t2_ready_back", 128'(fill_req_ready), 128'(1));

    // Memory stalls beat 2 for three cycles
    clear_logs();
    push_req(32'h600, acc);
    req_idle();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid && mem_req_addr == 32'h608) begin
        found = 1'b1;
        break;
      end
      sync();
    end
    chk("t3_found_beat2", 128'(found), 128'(1));
    mem_req_ready = 1'b0;
    stable = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      if (!(mem_req_valid && mem_req_addr == 32'h608)) stable = 1'b0;
    end
    chk("t3_stall_stable", 128'(stable), 128'(1));
    sync();
    mem_req_ready = 1'b1;
    wait_rsp(1, 40);
    chk_beats("t3_beat", 0, 32'h600, 32'h604, 32'h608, 32'h60C);
    chk_line("t3", 0, 32'h600, 128'hCAFE060C_CAFE0608_CAFE0604_CAFE0600);
    if (rcyc_q.size() > 0) chk("t3_latency", 128'(rcyc_q[0] - acc), 128'(10));

    // Reset during COLLECT after two responses
    clear_logs();
    push_req(32'h700, acc);
    req_idle();
    nrsp = 0;
    for (int i = 0; i < 30 && nrsp < 2; i++) begin
      sync();
      if (mem_rsp_valid) nrsp++;
    end
    rsp_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sync();
      if (!mem_req_valid) break;
    end
    chk("t4_two_rsps", 128'(nrsp), 128'(2));
    chk("t4_in_collect", 128'(fill_busy && !mem_req_valid), 128'(1));
    #1 RstN = 1'b0;
    #1;
    chk("t4_rst_rsp_vld", 128'(rsp.valid), 128'(0));
    chk("t4_rst_rsp_line", rsp.filled_instruction, 128'(0));
    chk("t4_rst_mreq_vld", 128'(mem_req_valid), 128'(0));
    chk("t4_rst_busy", 128'(fill_busy), 128'(0));
    repeat (2) @(posedge Clk);
    #2;
    rsp_en = 1'b1;
    RstN   = 1'b1;
    repeat (10) sync();
    chk("t4_no_rsp", 128'(rsp_q.size()), 128'(0));
    clear_logs();
    push_req(32'h400, acc);
    req_idle();
    wait_rsp(1, 40);
    chk_line("t4_new", 0, 32'h400, 128'hCAFE040C_CAFE0408_CAFE0404_CAFE0400);
    if (rcyc_q.size() > 0) chk("t4_latency", 128'(rcyc_q[0] - acc), 128'(7));

    // Last line in the address space
    clear_logs();
    push_req(32'hFFFF_FFF4, acc);
    req_idle();
    wait_rsp(1, 40);
    chk_beats("t5_beat", 0, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    chk_line("t5", 0, 32'hFFFF_FFF0, 128'h3501FFFC_3501FFF8_3501FFF4_3501FFF0);

    // Same line requested again while in flight
    clear_logs();
    push_req(32'h500, acc);
    req_idle();
    sync();
    sync();
    push_req(32'h508, a1);
    req_idle();
    repeat (30) sync();
    chk("t6_rsp_count", 128'(rsp_q.size()), 128'(DUP_RSPS));
    chk_line("t6_r0", 0, 32'h500, 128'hCAFE050C_CAFE0508_CAFE0504_CAFE0500);
    if (DUP_RSPS > 1) chk_line("t6_r1", 1, 32'h500, 128'hCAFE050C_CAFE0508_CAFE0504_CAFE0500);
    chk("t6_idle", 128'(fill_busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
